// File: rtl/seg7_pkg.sv
// Shared constants, segment table and output bundle for the 8-digit
// common-anode 7-segment scan driver.
package seg7_pkg;
  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t DISP_RESET = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};
endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit hex display driver with frame-aligned input
// shadowing, leading-zero blanking, dead time and halt blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value,
  input  logic        halt,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pre;
  logic [IW-1:0] idx, msd;
  logic [31:0]   sh_val;
  logic          sh_halt, ph, tick, frame, blank;
  logic [FW-1:0] fc;
  logic [6:0]    dec_seg;
  disp_t         disp_d, disp_q;

  assign tick  = (pre == PW'(CLK_DIV - 1));
  assign frame = tick && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      idx     <= '0;
      sh_val  <= '0;
      sh_halt <= 1'b0;
      fc      <= '0;
      ph      <= 1'b1;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) idx <= idx + IW'(1);
      if (frame) begin
        sh_val  <= value;
        sh_halt <= halt;
        // Counting starts only on the boundary after halt was captured;
        // dropping halt restores a steady phase for the very next frame.
        if (sh_halt && halt) begin
          if (fc == FW'(BLINK_FRAMES - 1)) begin
            fc <= '0;
            ph <= ~ph;
          end else begin
            fc <= fc + FW'(1);
          end
        end else begin
          fc <= '0;
          ph <= 1'b1;
        end
      end
    end
  end

  // Most significant nonzero digit; an all-zero word resolves to digit 0.
  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      if (sh_val[4*k +: 4] != 4'h0) msd = IW'(k);
  end

  assign blank = blank_lz && (idx > msd);

  seg7_hex_decode u_dec (
    .nib (sh_val[{idx, 2'b00} +: 4]),
    .seg (dec_seg)
  );

  always_comb begin
    disp_d     = DISP_RESET;
    disp_d.seg = blank ? SEG_BLANK : dec_seg;
    disp_d.dp  = blank | ~((idx == '0) && sh_halt);
    if ((int'(pre) >= DEAD) && ph && !blank)
      disp_d.an = ~(8'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_q <= DISP_RESET;
    else        disp_q <= disp_d;
  end

  assign an  = disp_q.an;
  assign seg = disp_q.seg;
  assign dp  = disp_q.dp;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle-count based reference model checked every
// cycle, plus directed literal expectations at chosen scan positions.
module tb_seg7_scan_driver;
  localparam int CD = 4;
  localparam int DT = 1;
  localparam int BF = 2;
  localparam int FRAME = 8 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] value = '0;
  logic        halt = 1'b0;
  logic        blank_lz = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vecs = 0;
  int errs = 0;

  seg7_scan_driver #(.CLK_DIV(CD), .DEAD(DT), .BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .halt     (halt),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  // Reference model: mdl_n = clock edges since reset release; the display
  // state for cycle n is derived arithmetically from n and the frame shadow.
  int          mdl_n = 0;
  logic [31:0] mv = '0;
  logic        mh = 1'b0;
  int          hf = 0;
  logic [7:0]  exp_an = 8'hFF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;

  function automatic logic [6:0] hexseg(logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic int top_digit(logic [31:0] v);
    int m = 0;
    for (int k = 0; k < 8; k++) if (v[4*k +: 4] != 4'h0) m = k;
    return m;
  endfunction

  function automatic bit is_blank(int n, logic [31:0] v, logic bl);
    return bl && (((n / CD) % 8) > top_digit(v));
  endfunction

  function automatic logic [7:0] model_an(int n, logic [31:0] v, int f, logic bl);
    int d = (n / CD) % 8;
    if ((n % CD) >= DT && ((f / BF) % 2) == 0 && !is_blank(n, v, bl))
      return ~(8'h01 << d);
    return 8'hFF;
  endfunction

  function automatic logic [6:0] model_seg(int n, logic [31:0] v, logic bl);
    int d = (n / CD) % 8;
    if (is_blank(n, v, bl)) return 7'h7F;
    return hexseg(v[4*d +: 4]);
  endfunction

  function automatic logic model_dp(int n, logic [31:0] v, logic h, logic bl);
    if (is_blank(n, v, bl)) return 1'b1;
    return !((((n / CD) % 8) == 0) && h);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_n   <= 0;
      mv      <= '0;
      mh      <= 1'b0;
      hf      <= 0;
      exp_an  <= 8'hFF;
      exp_seg <= 7'h7F;
      exp_dp  <= 1'b1;
    end else begin
      exp_an  <= model_an(mdl_n, mv, hf, blank_lz);
      exp_seg <= model_seg(mdl_n, mv, blank_lz);
      exp_dp  <= model_dp(mdl_n, mv, mh, blank_lz);
      if (mdl_n % FRAME == FRAME - 1) begin
        mv <= value;
        mh <= halt;
        hf <= (mh && halt) ? hf + 1 : 0;
      end
      mdl_n <= mdl_n + 1;
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      vecs++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        errs++;
        $display("FAIL cycle_cmp n=%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                 mdl_n, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic chk(string nm, logic [7:0] a, logic [6:0] s, logic d);
    vecs++;
    if (an !== a || seg !== s || dp !== d) begin
      errs++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
               nm, an, seg, dp, a, s, d);
    end
  endtask

  task automatic at(int tgt, string nm, logic [7:0] a, logic [6:0] s, logic d);
    int g = 0;
    while (mdl_n < tgt && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (mdl_n != tgt) begin
      vecs++;
      errs++;
      $display("FAIL %s: reached cycle %0d, wanted cycle %0d", nm, mdl_n, tgt);
    end else begin
      chk(nm, a, s, d);
    end
  endtask

  task automatic do_reset(logic [31:0] v, logic h, logic bl);
    @(negedge clk);
    rst_n = 1'b0;
    value = v;
    halt = h;
    blank_lz = bl;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    @(negedge clk);
    chk("reset_hold", 8'hFF, 7'h7F, 1'b1);

    // Scan order; first frame shows the reset shadow (zero).
    do_reset(32'h8765_4321, 1'b0, 1'b0);
    at(2,  "pre_frame_zero", 8'hFE, 7'h40, 1'b1);
    at(33, "scan_dead0",     8'hFF, 7'h79, 1'b1);
    at(34, "scan_d0",        8'hFE, 7'h79, 1'b1);
    at(38, "scan_d1",        8'hFD, 7'h24, 1'b1);
    at(62, "scan_d7",        8'h7F, 7'h00, 1'b1);
    at(66, "scan_repeat",    8'hFE, 7'h79, 1'b1);
    at(86, "scan_f2_d5",     8'hDF, 7'h02, 1'b1);

    // Asynchronous reset in the middle of digit 5's slot.
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 8'hFF, 7'h7F, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at(2, "restart_d0", 8'hFE, 7'h40, 1'b1);

    // Leading-zero blanking.
    do_reset(32'h0000_00A0, 1'b0, 1'b1);
    at(34, "lz_d0",   8'hFE, 7'h40, 1'b1);
    at(38, "lz_d1",   8'hFD, 7'h08, 1'b1);
    at(42, "lz_d2",   8'hFF, 7'h7F, 1'b1);
    value = 32'h0;
    at(66, "zero_d0", 8'hFE, 7'h40, 1'b1);
    at(70, "zero_d1", 8'hFF, 7'h7F, 1'b1);

    // No tearing: change lands while digit 3 is lit.
    do_reset(32'h1111_1111, 1'b0, 1'b0);
    at(46, "tear_d3", 8'hF7, 7'h79, 1'b1);
    value = 32'h2222_2222;
    at(54, "tear_d5",   8'hDF, 7'h79, 1'b1);
    at(62, "tear_d7",   8'h7F, 7'h79, 1'b1);
    at(66, "tear_next", 8'hFE, 7'h24, 1'b1);

    // Halt blink: two frames lit, two dark, then release.
    do_reset(32'h0000_0022, 1'b1, 1'b0);
    at(34,  "halt_d0",    8'hFE, 7'h24, 1'b0);
    at(38,  "halt_d1",    8'hFD, 7'h24, 1'b1);
    at(66,  "halt_f2",    8'hFE, 7'h24, 1'b0);
    at(98,  "halt_dark",  8'hFF, 7'h24, 1'b0);
    at(130, "halt_dark2", 8'hFF, 7'h24, 1'b0);
    at(162, "halt_relit", 8'hFE, 7'h24, 1'b0);
    halt = 1'b0;
    at(194, "unhalt",     8'hFE, 7'h24, 1'b1);
    at(226, "unhalt2",    8'hFE, 7'h24, 1'b1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
